mbus_tx_arbiter: RTL and testbench

//  Shares one mbus_master_node TX port among NUM_REQ local requesters (CPU, DMA, IRQ forwarder, ...).

---
 rtl/mbus_tx_arbiter_pkg.sv | 18 +
 rtl/mbus_tx_arbiter_rr_picker.sv | 27 ++
 rtl/mbus_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mbus_tx_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared widths, counter size and FSM state encoding for the mbus TX arbiter.
// Widths default to the mbus address/data bus definitions.
package mbus_tx_arbiter_pkg;

    localparam int MBUS_ADDR_WIDTH = 32;
    localparam int MBUS_DATA_WIDTH = 32;
    localparam int CNT_WIDTH       = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACKLO,
        S_NEXT,
        S_RESP,
        S_RACK
    } state_t;

endpackage

// File: rtl/mbus_tx_arbiter_rr_picker.sv
// Combinational one-hot pick: priority requesters shadow the rest, round-robin from ptr_i.
// Zero latency; gnt_o is all-zero when no request is present.
module mbus_rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  prio_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] hi;
    logic [N-1:0] cand;
    logic [N-1:0] upper;
    logic [N-1:0] sel;

    // Candidates at or above the pointer go first; otherwise wrap to the lowest index.
    always_comb begin
        hi    = req_i & prio_i;
        cand  = (|hi) ? hi : req_i;
        upper = cand & ~(({{(N-1){1'b0}}, 1'b1} << ptr_i) - {{(N-1){1'b0}}, 1'b1});
        sel   = (|upper) ? upper : cand;
        gnt_o = sel & (~sel + {{(N-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Shares one mbus master-node TX port among NUM_REQ requesters for whole messages.
// VALID at edge k gives TX_REQ at k+1; requesters wait on the 4-phase REQ_ACK while the node stalls.
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = MBUS_ADDR_WIDTH,
    parameter int DATA_WIDTH   = MBUS_DATA_WIDTH,
    parameter int RESP_TIMEOUT = 1023
) (
    input  logic                          CLKIN,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_PRIORITY,
    input  logic [NUM_REQ-1:0]            REQ_PEND,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [NUM_REQ-1:0]            REQ_SUCC,
    output logic [NUM_REQ-1:0]            REQ_FAIL,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_PEND,
    output logic                          TX_REQ,
    output logic                          PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic                          TIMEOUT_ERR
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                 state_q;
    logic [NUM_REQ-1:0]     gnt_q, ack_q, succ_q, fail_q;
    logic [IW-1:0]          rr_q, rr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   pend_q, prio_q, txreq_q, rack_q, terr_q;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0]  pick_data, own_data;
    logic [IW-1:0]          own_idx;
    logic                   pick_prio, pick_pend, own_pend, own_valid;

    mbus_rr_picker #(.N(NUM_REQ), .PW(IW)) u_picker (
        .req_i  (REQ_VALID),
        .prio_i (REQ_PRIORITY),
        .ptr_i  (rr_q),
        .gnt_o  (pick_gnt)
    );

    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        own_data  = '0;
        own_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (gnt_q[i]) begin
                own_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                own_idx  = IW'(i);
            end
        end
        pick_prio = |(REQ_PRIORITY & pick_gnt);
        pick_pend = |(REQ_PEND & pick_gnt);
        own_pend  = |(REQ_PEND & gnt_q);
        own_valid = |(REQ_VALID & gnt_q);
        rr_d      = (own_idx == IW'(NUM_REQ - 1)) ? '0 : own_idx + IW'(1);
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            succ_q  <= '0;
            fail_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            prio_q  <= 1'b0;
            txreq_q <= 1'b0;
            rack_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            succ_q <= '0;
            fail_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|REQ_VALID) begin
                        gnt_q   <= pick_gnt;
                        prio_q  <= pick_prio;
                        addr_q  <= pick_addr;
                        data_q  <= pick_data;
                        pend_q  <= pick_pend;
                        txreq_q <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ, S_ACKLO, S_NEXT: begin
                    // A bus abort ends the message wherever it is; the result is still acknowledged.
                    if (TX_FAIL) begin
                        txreq_q <= 1'b0;
                        ack_q   <= '0;
                        fail_q  <= gnt_q;
                        rack_q  <= 1'b1;
                        state_q <= S_RACK;
                    end else if (state_q == S_REQ) begin
                        if (TX_ACK) begin
                            txreq_q <= 1'b0;
                            ack_q   <= gnt_q;
                            state_q <= S_ACKLO;
                        end
                    end else if (state_q == S_ACKLO) begin
                        if (!TX_ACK && !own_valid) begin
                            ack_q <= '0;
                            if (pend_q) begin
                                state_q <= S_NEXT;
                            end else begin
                                cnt_q   <= '0;
                                state_q <= S_RESP;
                            end
                        end
                    end else if (own_valid) begin
                        data_q  <= own_data;
                        pend_q  <= own_pend;
                        txreq_q <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_RESP: begin
                    if (TX_SUCC || TX_FAIL) begin
                        rack_q <= 1'b1;
                        if (TX_FAIL) begin
                            fail_q <= gnt_q;
                        end else begin
                            succ_q <= gnt_q;
                        end
                        state_q <= S_RACK;
                    end else if (cnt_q == CNT_WIDTH'(RESP_TIMEOUT - 1)) begin
                        // Timed-out owner also gives up its round-robin turn.
                        fail_q  <= gnt_q;
                        terr_q  <= 1'b1;
                        gnt_q   <= '0;
                        rr_q    <= rr_d;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RACK: begin
                    if (!TX_SUCC && !TX_FAIL) begin
                        rack_q  <= 1'b0;
                        gnt_q   <= '0;
                        rr_q    <= rr_d;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign REQ_ACK     = ack_q;
    assign REQ_SUCC    = succ_q;
    assign REQ_FAIL    = fail_q;
    assign GRANT       = gnt_q;
    assign TX_ADDR     = addr_q;
    assign TX_DATA     = data_q;
    assign TX_PEND     = pend_q;
    assign TX_REQ      = txreq_q;
    assign PRIORITY    = prio_q;
    assign TX_RESP_ACK = rack_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Bench for mbus_tx_arbiter: requester and master-node agents, a message-level model and directed scenarios.
module tb_mbus_tx_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid, req_prio, req_pend;
    logic [127:0] req_addr, req_data;
    logic [3:0]   REQ_ACK, REQ_SUCC, REQ_FAIL, GRANT;
    logic [31:0]  TX_ADDR, TX_DATA;
    logic         TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK, TIMEOUT_ERR;
    logic         tx_ack, tx_succ, tx_fail;

    mbus_tx_arbiter #(.NUM_REQ(4), .RESP_TIMEOUT(15)) dut (
        .CLKIN        (clk),
        .RESET        (rst),
        .REQ_VALID    (req_valid),
        .REQ_PRIORITY (req_prio),
        .REQ_PEND     (req_pend),
        .REQ_ADDR     (req_addr),
        .REQ_DATA     (req_data),
        .REQ_ACK      (REQ_ACK),
        .REQ_SUCC     (REQ_SUCC),
        .REQ_FAIL     (REQ_FAIL),
        .GRANT        (GRANT),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA      (TX_DATA),
        .TX_PEND      (TX_PEND),
        .TX_REQ       (TX_REQ),
        .PRIORITY     (PRIORITY),
        .TX_ACK       (tx_ack),
        .TX_SUCC      (tx_succ),
        .TX_FAIL      (tx_fail),
        .TX_RESP_ACK  (TX_RESP_ACK),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_expired(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event within budget", nm);
    endtask

    // Per-requester word tables; resp_mode: 0 succ, 1 fail, 2 silent, 3 abort, 4 never ack, 5 succ+fail
    logic [31:0] wd_addr [4][16];
    logic [31:0] wd_data [4][16];
    bit          wd_pend [4][16];
    bit          wd_prio [4][16];
    int          wcnt [4];
    int          wpos [4];
    int          resp_mode;
    bit          last_word;

    task automatic add_word(input int r, input logic [31:0] a, input logic [31:0] d,
                            input bit p, input bit pr);
        wd_addr[r][wcnt[r]] = a;
        wd_data[r][wcnt[r]] = d;
        wd_pend[r][wcnt[r]] = p;
        wd_prio[r][wcnt[r]] = pr;
        wcnt[r]++;
    endtask

    // Requester agents: 4-phase, VALID held until REQ_ACK, message dropped on a fail pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i]) begin
                        if (REQ_ACK[i]) begin
                            req_valid[i] = 1'b0;
                            wpos[i]++;
                        end else if (REQ_FAIL[i]) begin
                            req_valid[i] = 1'b0;
                            while (wpos[i] < wcnt[i] && wd_pend[i][wpos[i]]) wpos[i]++;
                            wpos[i]++;
                        end
                    end else if (!REQ_ACK[i] && wpos[i] < wcnt[i]) begin
                        req_addr[i*32 +: 32] = wd_addr[i][wpos[i]];
                        req_data[i*32 +: 32] = wd_data[i][wpos[i]];
                        req_pend[i]  = wd_pend[i][wpos[i]];
                        req_prio[i]  = wd_prio[i][wpos[i]];
                        req_valid[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Master-node agent.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_ack = 0; tx_succ = 0; tx_fail = 0; last_word = 0;
            end else if (tx_succ || tx_fail) begin
                if (TX_RESP_ACK) begin
                    tx_succ = 0;
                    tx_fail = 0;
                end
            end else if (tx_ack) begin
                if (!TX_REQ) tx_ack = 0;
            end else if (TX_REQ && resp_mode == 3) begin
                tx_fail = 1;
            end else if (TX_REQ && resp_mode != 4) begin
                tx_ack    = 1;
                last_word = !TX_PEND;
            end else if (last_word && !TX_REQ && REQ_ACK == 4'b0) begin
                last_word = 0;
                case (resp_mode)
                    0:       tx_succ = 1;
                    1:       tx_fail = 1;
                    5:       begin tx_succ = 1; tx_fail = 1; end
                    default: ;
                endcase
            end
        end
    end

    // Message-level model: winner by class then circular distance from the pointer.
    function automatic int model_pick(input logic [3:0] v, input logic [3:0] p, input int ptr);
        int  best, bestd, d;
        bit  any_p;
        best  = -1;
        bestd = 99;
        any_p = (v & p) != 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (!any_p || p[i])) begin
                d = (i - ptr + 4) % 4;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        return (w < 0) ? 4'b0 : (4'b1 << w);
    endfunction

    int          cyc = 0, owner = -1, mptr = 0, nlog = 0, nres = 0, ack_fall = 0, to_lat = -1;
    bit          terr_m = 0, rack_seen = 0;
    logic [3:0]  prev_gnt = 0, prev_res = 0, prev_ack = 0, res;
    logic        prev_txreq = 0;
    logic [31:0] msg_addr;
    int          grant_log [64];
    bit          prio_log [64];
    int          succ_seen [4];
    int          fail_seen [4];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                chk("reset_outs", {GRANT, REQ_ACK, REQ_SUCC, REQ_FAIL, TX_REQ, TX_PEND, PRIORITY,
                                   TX_RESP_ACK, TIMEOUT_ERR}, 64'd0);
                owner = -1; mptr = 0; terr_m = 0;
                prev_gnt = 0; prev_res = 0; prev_ack = 0; prev_txreq = 0;
                continue;
            end
            res = REQ_SUCC | REQ_FAIL;
            if (prev_res != 4'b0) chk("pulse_width", res, 0);
            if (GRANT != 4'b0 && prev_gnt == 4'b0) begin
                owner = model_pick(req_valid, req_prio, mptr);
                chk("grant_pick", GRANT, onehot(owner));
                if (owner >= 0) begin
                    msg_addr = wd_addr[owner][wpos[owner]];
                    chk("prio_latch", PRIORITY, wd_prio[owner][wpos[owner]]);
                    grant_log[nlog] = owner;
                    prio_log[nlog]  = PRIORITY;
                    nlog++;
                end
            end else if (GRANT != 4'b0) begin
                chk("grant_hold", GRANT, onehot(owner));
            end
            if (TX_REQ && !prev_txreq && owner >= 0) begin
                chk("tx_addr", TX_ADDR, msg_addr);
                chk("tx_data", TX_DATA, wd_data[owner][wpos[owner]]);
                chk("tx_pend", TX_PEND, wd_pend[owner][wpos[owner]]);
            end
            if (REQ_ACK != 4'b0) chk("ack_owner", REQ_ACK, onehot(owner));
            if (prev_ack != 4'b0 && REQ_ACK == 4'b0) ack_fall = cyc;
            if (TX_RESP_ACK) rack_seen = 1;
            if (res != 4'b0) begin
                chk("result", {REQ_SUCC, REQ_FAIL},
                    {(resp_mode == 0) ? onehot(owner) : 4'b0, (resp_mode != 0) ? onehot(owner) : 4'b0});
                if (resp_mode == 2) begin
                    to_lat = cyc - ack_fall;
                    chk("timeout_lat", to_lat, 15);
                    terr_m = 1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (REQ_SUCC[i]) succ_seen[i]++;
                    if (REQ_FAIL[i]) fail_seen[i]++;
                end
                nres++;
            end
            chk("timeout_err", TIMEOUT_ERR, terr_m);
            if (prev_gnt != 4'b0 && GRANT == 4'b0 && owner >= 0) begin
                mptr  = (owner + 1) % 4;
                owner = -1;
            end
            prev_gnt   = GRANT;
            prev_res   = res;
            prev_ack   = REQ_ACK;
            prev_txreq = TX_REQ;
        end
    end

    task automatic wait_idle(input string nm, input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #2;
            done = 1;
            for (int i = 0; i < 4; i++) if (wpos[i] < wcnt[i]) done = 0;
            if (req_valid != 4'b0 || GRANT != 4'b0 || TX_RESP_ACK || tx_succ || tx_fail) done = 0;
        end
        if (!done) wait_expired(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        req_valid = 0;
        for (int i = 0; i < 4; i++) wcnt[i] = wpos[i];
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    int  base, r0;
    bit  seen;

    initial begin
        rst = 1; req_valid = 0; req_prio = 0; req_pend = 0; req_addr = 0; req_data = 0;
        tx_ack = 0; tx_succ = 0; tx_fail = 0; last_word = 0; resp_mode = 0;
        for (int i = 0; i < 4; i++) begin
            wcnt[i] = 0; wpos[i] = 0; succ_seen[i] = 0; fail_seen[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        #2;
        chk("idle_grant", GRANT, 0);
        chk("idle_txreq", TX_REQ, 0);

        // 1: single word from requester 1, one-cycle latency, success
        add_word(1, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 0);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = req_valid[1];
        end
        if (!seen) wait_expired("t1_valid");
        @(posedge clk);
        #2;
        chk("t1_txreq", TX_REQ, 1);
        chk("t1_grant", GRANT, 4'b0010);
        chk("t1_addr", TX_ADDR, 32'h0000_00A5);
        chk("t1_data", TX_DATA, 32'hDEAD_BEEF);
        wait_idle("t1_idle", 100);
        chk("t1_succ_cnt", succ_seen[1], 1);
        chk("t1_rack_seen", rack_seen, 1);

        // 2: round robin from pointer 0
        do_reset();
        base = nlog;
        add_word(0, 32'h10, 32'h1000, 0, 0);
        add_word(2, 32'h12, 32'h1002, 0, 0);
        add_word(3, 32'h13, 32'h1003, 0, 0);
        wait_idle("t2_idle_a", 200);
        chk("t2_first", grant_log[base], 0);
        chk("t2_second", grant_log[base+1], 2);
        chk("t2_third", grant_log[base+2], 3);
        add_word(0, 32'h20, 32'h2000, 0, 0);
        add_word(3, 32'h23, 32'h2003, 0, 0);
        wait_idle("t2_idle_b", 200);
        chk("t2_rerequest", grant_log[base+3], 0);
        chk("t2_rerequest2", grant_log[base+4], 3);

        // 3: priority class beats round robin
        add_word(0, 32'h30, 32'h3000, 0, 0);
        add_word(3, 32'h33, 32'h3003, 0, 1);
        wait_idle("t3_idle", 200);
        chk("t3_prio_winner", grant_log[base+5], 3);
        chk("t3_prio_bus", prio_log[base+5], 1);
        chk("t3_then", grant_log[base+6], 0);

        // 4: three-word message holds the grant against another requester
        add_word(2, 32'h0000_0100, 32'hA1, 1, 0);
        add_word(2, 32'h0000_0200, 32'hA2, 1, 0);
        add_word(2, 32'h0000_0300, 32'hA3, 0, 0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = (GRANT == 4'b0100);
        end
        if (!seen) wait_expired("t4_grant");
        add_word(1, 32'h41, 32'h4001, 0, 0);
        wait_idle("t4_idle", 300);
        chk("t4_owner", grant_log[base+7], 2);
        chk("t4_after", grant_log[base+8], 1);

        // bus abort mid-message, then simultaneous SUCC and FAIL
        resp_mode = 3;
        add_word(0, 32'h50, 32'h5000, 1, 0);
        add_word(0, 32'h50, 32'h5001, 0, 0);
        wait_idle("abort_idle", 200);
        resp_mode = 5;
        add_word(0, 32'h51, 32'h5100, 0, 0);
        wait_idle("both_idle", 200);
        chk("abort_fail_cnt", fail_seen[0], 2);

        // 5: silent node, response timeout
        resp_mode = 2;
        add_word(3, 32'h60, 32'h6000, 0, 0);
        wait_idle("t5_idle", 200);
        chk("t5_timeout_err", TIMEOUT_ERR, 1);
        chk("t5_latency", to_lat, 15);
        chk("t5_fail_cnt", fail_seen[3], 1);

        // 6: reset while the word is still requested
        resp_mode = 4;
        add_word(1, 32'h70, 32'h7000, 0, 0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = TX_REQ;
        end
        if (!seen) wait_expired("t6_txreq");
        r0 = nres;
        @(negedge clk);
        rst = 1;
        req_valid = 0;
        for (int i = 0; i < 4; i++) wcnt[i] = wpos[i];
        @(posedge clk);
        #2;
        chk("t6_txreq", TX_REQ, 0);
        chk("t6_grant", GRANT, 0);
        chk("t6_ack", REQ_ACK, 0);
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("t6_no_result", nres, r0);
        chk("t6_terr_clr", TIMEOUT_ERR, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
